// File: rtl/timer_ctrl_master.sv
// Bus-initiator sequencer for the 2-bit-address memory-mapped timer: programs TH/TL/TCon,
// services each interrupt by reading and re-arming TCon, and stops the timer on request.
module timer_ctrl_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] period,
    input  logic        irq_mode,
    output logic [1:0]  Address,
    output logic [31:0] Write_data,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] Read_data,
    input  logic        IRQ,
    output logic        busy,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic [2:0]  status
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_TH   = 3'd1,
        S_WR_TL   = 3'd2,
        S_WR_CON  = 3'd3,
        S_RUN     = 3'd4,
        S_RD_CON  = 3'd5,
        S_CLR_CON = 3'd6,
        S_WR_STOP = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_period;
    logic        r_irq_mode;
    logic        r_stop_pend;
    logic [15:0] r_tick_count;
    logic [2:0]  r_status;
    logic        w_accept;
    logic        w_stop_window;

    assign w_accept      = (r_state == S_IDLE) && start;
    // Stop is remembered only while a fixed bus sequence is in flight; RUN reacts to it directly.
    assign w_stop_window = (r_state == S_WR_TH)  || (r_state == S_WR_TL) ||
                           (r_state == S_WR_CON) || (r_state == S_RD_CON) ||
                           (r_state == S_CLR_CON);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Captured command, stop-pending flag, tick counter and interrupt status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period     <= 32'd0;
            r_irq_mode   <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_tick_count <= 16'd0;
            r_status     <= 3'd0;
        end else begin
            if (w_accept) begin
                r_period     <= period;
                r_irq_mode   <= irq_mode;
                r_tick_count <= 16'd0;
            end else if (r_state == S_CLR_CON) begin
                r_tick_count <= r_tick_count + 16'd1;
            end else begin
                r_tick_count <= r_tick_count;
            end
            if (r_state == S_WR_STOP) begin
                r_stop_pend <= 1'b0;
            end else if (stop && w_stop_window) begin
                r_stop_pend <= 1'b1;
            end else begin
                r_stop_pend <= r_stop_pend;
            end
            if (r_state == S_RD_CON) begin
                r_status <= Read_data[2:0];
            end else begin
                r_status <= r_status;
            end
        end
    end

    // Next-state logic and bus decode from the state register
    always_comb begin
        w_next_state = r_state;
        Address      = 2'b00;
        Write_data   = 32'd0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        tick         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_WR_TH;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WR_TH: begin
                Address      = 2'b00;
                Write_data   = r_period;
                MemWrite     = 1'b1;
                w_next_state = S_WR_TL;
            end
            S_WR_TL: begin
                Address      = 2'b01;
                Write_data   = r_period;
                MemWrite     = 1'b1;
                w_next_state = S_WR_CON;
            end
            S_WR_CON: begin
                Address      = 2'b10;
                Write_data   = {29'd0, 1'b0, r_irq_mode, 1'b1};
                MemWrite     = 1'b1;
                w_next_state = S_RUN;
            end
            S_RUN: begin
                if (r_stop_pend || stop) begin
                    w_next_state = S_WR_STOP;
                end else if (IRQ) begin
                    w_next_state = S_RD_CON;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_RD_CON: begin
                Address      = 2'b10;
                MemRead      = 1'b1;
                w_next_state = S_CLR_CON;
            end
            S_CLR_CON: begin
                // Rewriting enable/mode with bit 2 low acknowledges the interrupt.
                Address      = 2'b10;
                Write_data   = {29'd0, 1'b0, r_irq_mode, 1'b1};
                MemWrite     = 1'b1;
                tick         = 1'b1;
                w_next_state = S_RUN;
            end
            S_WR_STOP: begin
                Address      = 2'b10;
                Write_data   = 32'd0;
                MemWrite     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign busy       = (r_state != S_IDLE);
    assign tick_count = r_tick_count;
    assign status     = r_status;

endmodule

// File: doc/timer_ctrl_master.md
# timer_ctrl_master

Bus-initiator sequencer that drives the 2-bit-address memory-mapped timer interface from the master side. Given a start command, it programs the reload value, counter value and control word. It then services each timer interrupt by reading and clearing the control register, and stops the timer on request. It sits between the CPU's control registers and the timer peripheral, so the CPU does not have to run an interrupt handler just to re-arm the timer.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin programming sequence; sampled only in IDLE
- stop  in  1  request timer stop; sampled every cycle
- period  in  32  reload/initial count value; captured on accepted start
- irq_mode  in  1  interrupt enable written to TCon[1]; captured on accepted start
- Address  out  2  peripheral register select: 00 TH, 01 TL, 10 TCon
- Write_data  out  32  write data to peripheral
- MemWrite  out  1  write strobe; peripheral samples on the same rising edge
- MemRead  out  1  read strobe; Read_data is valid combinationally in the same cycle
- Read_data  in  32  peripheral read data
- IRQ  in  1  level interrupt from peripheral (TCon[2])
- busy  out  1  high in every state except IDLE
- tick  out  1  one-cycle pulse per serviced interrupt
- tick_count  out  16  serviced interrupts since last accepted start
- status  out  3  TCon[2:0] captured by the last interrupt-service read

## Operation
- States: IDLE, WR_TH, WR_TL, WR_CON, RUN, RD_CON, CLR_CON, WR_STOP.
- Bus outputs are decoded from the state register and the captured period/irq_mode. At most one access happens per cycle, and MemRead and MemWrite are never high together.
- IDLE: Address=00, Write_data=0, MemWrite=0, MemRead=0.
  - If start=1: capture period and irq_mode, clear tick_count, go to WR_TH.
  - If start=0: stay in IDLE. stop is ignored.
- WR_TH: Address=00, Write_data=period, MemWrite=1 -> WR_TL.
- WR_TL: Address=01, Write_data=period, MemWrite=1 -> WR_CON.
- WR_CON: Address=10, Write_data={29'b0, 1'b0, irq_mode, 1'b1}, MemWrite=1 -> RUN.
- RUN: no bus access. Transitions, in priority order:
  - stop pending or stop=1 -> WR_STOP.
  - IRQ=1 -> RD_CON.
  - Otherwise stay in RUN.
- RD_CON: Address=10, MemRead=1. Latch Read_data[2:0] into status -> CLR_CON.
- CLR_CON: Address=10, Write_data={29'b0, 1'b0, irq_mode, 1'b1}, MemWrite=1. This clears TCon[2]. tick=1, tick_count increments -> RUN.
- WR_STOP: Address=10, Write_data=0, MemWrite=1. Clear the stop-pending flag -> IDLE.
- Stop pending:
  - stop=1 in WR_TH, WR_TL, WR_CON, RD_CON or CLR_CON sets a stop-pending flag. The current sequence finishes, and RUN exits to WR_STOP on the cycle it is entered.
  - stop in IDLE or WR_STOP is ignored.
- start while busy is ignored. It is not queued.
- tick_count wraps FFFF -> 0000 without saturation.
- If irq_mode=0, RUN waits only for stop. If IRQ is seen high anyway, it is still serviced.

## Timing
- Reset values: state IDLE, busy=0, tick=0, tick_count=0, status=000, Address=00, Write_data=0, MemWrite=0, MemRead=0. Captured period, captured irq_mode and stop-pending are all 0.
- Reset asserted mid-sequence aborts immediately. No stop write is issued.
- start high at edge k (in IDLE):
  - WR_TH is driven in cycle k..k+1.
  - WR_TL follows in the next cycle, then WR_CON.
  - RUN is entered after edge k+3.
  - Programming latency is 3 bus cycles.
- IRQ high in RUN at edge m:
  - RD_CON is driven in cycle m..m+1.
  - CLR_CON is driven in cycle m+1..m+2, with tick high.
  - RUN is re-entered after edge m+2. IRQ is low from then on because the peripheral cleared it.
  - Service latency is 2 bus cycles.
- tick_count and status update on the edge that ends CLR_CON and RD_CON respectively.
- stop=1 in RUN at edge s: WR_STOP is driven in cycle s..s+1, and busy=0 from edge s+1.
- stop and IRQ both high in RUN: stop wins. The interrupt is not serviced and tick_count is unchanged.

## Test plan
- Reset, then start=1 with period=0xFFFFFFF0 and irq_mode=1:
  - Bus trace: (00, FFFFFFF0, W), then (01, FFFFFFF0, W), then (10, 00000003, W).
  - busy=1 from the first edge.
- Using the timer model, wait for the first IRQ:
  - RD_CON read on address 10; status=111.
  - CLR_CON writes 00000003.
  - tick pulses once; tick_count=1; IRQ drops.
  - Repeat for 3 interrupts: tick_count=3.
- stop=1 asserted in WR_TL:
  - WR_CON completes, then WR_STOP writes (10, 00000000).
  - Returns to IDLE; busy=0; no RUN dwell.
- stop and IRQ high in the same RUN cycle: WR_STOP occurs, no RD_CON, tick_count unchanged.
- start pulsed during RUN: ignored. The captured period is unchanged and no TH/TL writes occur.
- Preload tick_count=FFFF via 65535 services, or a forced internal value. The next service gives tick_count=0000.
- Assert reset mid-CLR_CON: all outputs return to their reset values on the same cycle.
